// File: rtl/muldiv_pkg.sv
// Shared width, opcode and FSM state definitions for the multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_e;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Operand/request, HiLo-write and result signals of the multiply/divide unit.
interface muldiv_unit_if;
  import muldiv_pkg::*;

  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            op;
  logic            start;
  logic            wr_hi;
  logic            wr_lo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output a, b, op, start, wr_hi, wr_lo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  a, b, op, start, wr_hi, wr_lo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration: LSB-first shift-add for MULT, restoring shift-subtract for DIV.
module muldiv_step
  import muldiv_pkg::*;
(
  input  op_e                 op,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     operand,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   top;
  logic [XLEN-1:0] diff;
  logic            ge;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    // Partial remainder shifted left by one can reach XLEN+1 bits.
    top      = acc[2*XLEN-1:XLEN-1];
    ge       = (top >= {1'b0, operand});
    diff     = top[XLEN-1:0] - operand;
    acc_next = '0;
    if (op == OP_MULT) begin
      acc_next = {sum, acc[XLEN-1:1]};
    end else if (ge) begin
      acc_next = {diff, acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {top[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with HiLo register.
// Define MULDIV_SIGNED_EN for two's-complement operands; unsigned otherwise.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [5:0]        count_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   opnd_q;
  op_e               op_q;
  logic              neg_quo, neg_rem, div0;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   hi_q, lo_q;

  logic              sign_a, sign_b;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   res_hi, res_lo;

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
`ifdef MULDIV_SIGNED_EN
    sign_a = bus.a[XLEN-1];
    sign_b = bus.b[XLEN-1];
`else
    sign_a = 1'b0;
    sign_b = 1'b0;
`endif
    mag_a = magnitude(bus.a, sign_a);
    mag_b = magnitude(bus.b, sign_b);
  end

  muldiv_step u_step (
    .op       (op_q),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (acc_step)
  );

  // Sign fix-up; a zero divisor leaves remainder = dividend but forces quotient to all ones.
  always_comb begin
    prod_fix = neg_quo ? (~acc_q + 1'b1) : acc_q;
    res_hi   = '0;
    res_lo   = '0;
    if (op_q == OP_MULT) begin
      {res_hi, res_lo} = prod_fix;
    end else begin
      res_lo = div0 ? '1 : magnitude(acc_q[XLEN-1:0], neg_quo);
      res_hi = magnitude(acc_q[2*XLEN-1:XLEN], neg_rem);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_RUN;
      S_RUN:    if (count_q == 6'd31) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= OP_MULT;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            count_q <= '0;
            busy_q  <= 1'b1;
            op_q    <= op_e'(bus.op);
            opnd_q  <= mag_b;
            acc_q   <= {{XLEN{1'b0}}, mag_a};
            neg_quo <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            div0    <= (bus.b == '0);
          end else begin
            if (bus.wr_hi) hi_q <= bus.wdata;
            if (bus.wr_lo) lo_q <= bus.wdata;
          end
        end
        S_RUN: begin
          acc_q   <= acc_step;
          count_q <= (count_q == 6'd31) ? '0 : count_q + 6'd1;
        end
        S_FINISH: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; expectations follow MULDIV_SIGNED_EN when defined.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  muldiv_unit_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int since = 0;
  int done_cnt = 0;
  logic [31:0] q_hi[$];
  logic [31:0] q_lo[$];
  string       q_name[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the cycle after the accepting edge is cycle 1; done must appear in cycle 34.
  always @(negedge clk) begin
    since++;
    if (bus.done === 1'b1) begin
      done_cnt++;
      if (q_hi.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        automatic string nm = q_name.pop_front();
        automatic logic [31:0] eh = q_hi.pop_front();
        automatic logic [31:0] el = q_lo.pop_front();
        check({nm, "_hi"}, bus.hi, eh);
        check({nm, "_lo"}, bus.lo, el);
        check({nm, "_latency"}, since, 34);
      end
    end
  end

  task automatic issue(input logic o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el,
                       input bit push, input string name);
    @(negedge clk);
    bus.op = o; bus.a = av; bus.b = bv; bus.start = 1'b1;
    @(posedge clk);
    since = 0;
    if (push) begin
      q_name.push_back(name); q_hi.push_back(eh); q_lo.push_back(el);
    end
    #1;
    bus.start = 1'b0;
    check({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
    bus.a = ~av; bus.b = ~bv;
  endtask

  task automatic expect_single_done(input string name, input int n0);
    repeat (40) @(posedge clk);
    check({name, "_done_count"}, done_cnt, n0 + 1);
  endtask

  logic [31:0] ff_hi, neg_hi, neg_lo;
  int n0;

  initial begin
`ifdef MULDIV_SIGNED_EN
    ff_hi = 32'h0000_0000; neg_hi = 32'hFFFF_FFFF; neg_lo = 32'hFFFF_FFFD;
`else
    ff_hi = 32'hFFFF_FFFE; neg_hi = 32'h0000_0001; neg_lo = 32'h7FFF_FFFC;
`endif
    bus.a = '0; bus.b = '0; bus.op = 1'b0; bus.start = 1'b0;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    @(negedge clk) reset = 1'b0;

    n0 = done_cnt; issue(OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1, "mul_7x6");
    expect_single_done("mul_7x6", n0);
    n0 = done_cnt; issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ff_hi, 32'd1, 1'b1, "mul_ffxff");
    expect_single_done("mul_ffxff", n0);
    n0 = done_cnt; issue(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1, "div_100_7");
    expect_single_done("div_100_7", n0);
    n0 = done_cnt; issue(OP_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, "div_5_0");
    expect_single_done("div_5_0", n0);
    n0 = done_cnt; issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, neg_hi, neg_lo, 1'b1, "div_m7_2");
    expect_single_done("div_m7_2", n0);

    // Second start in cycle 5 and a wr_hi while busy must both be ignored.
    n0 = done_cnt; issue(OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b1, "mul_busy");
    repeat (5) @(negedge clk);
    bus.op = OP_DIV; bus.a = 32'd9; bus.b = 32'd3; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.wr_hi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.wr_hi = 1'b0;
    @(negedge clk);
    check("busy_hi_hold", bus.hi, neg_hi);
    check("busy_still", {31'b0, bus.busy}, 32'd1);
    expect_single_done("mul_busy", n0);

    @(negedge clk); bus.wr_hi = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk); bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wdata = 32'h5678;
    @(negedge clk); bus.wr_lo = 1'b0;
    check("mthi", bus.hi, 32'h1234);
    check("mtlo", bus.lo, 32'h5678);

    // start wins over a coincident wr_lo.
    n0 = done_cnt;
    @(negedge clk);
    bus.op = OP_MULT; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
    bus.wr_lo = 1'b1; bus.wdata = 32'hAAAA;
    @(posedge clk);
    since = 0;
    q_name.push_back("mul_coinc"); q_hi.push_back(32'd0); q_lo.push_back(32'd6);
    #1;
    bus.start = 1'b0; bus.wr_lo = 1'b0;
    check("coinc_lo_drop", bus.lo, 32'h5678);
    expect_single_done("mul_coinc", n0);

    // Reset in cycle 10 aborts the operation.
    @(negedge clk); bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk); bus.wr_hi = 1'b0; bus.wdata = 32'h5678;
    @(negedge clk); bus.wr_lo = 1'b0;
    check("pre_hi", bus.hi, 32'h1234);
    check("pre_lo", bus.lo, 32'h5678);
    issue(OP_MULT, 32'd7, 32'd6, 32'd0, 32'd0, 1'b0, "mul_abort");
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    n0 = done_cnt;
    repeat (40) @(posedge clk);
    check("abort_no_done", done_cnt, n0);
    check("queue_empty", q_hi.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
